// File: rtl/motoro3_step_seq.sv
// motoro3_step_seq: 6-step trapezoidal commutation sequencer.
// Walks step index 0..5 with a programmable step period, blanks all phase
// enables for DEAD_CLK cycles at each step start, and emits step/round pulses.
module motoro3_step_seq #(
  parameter int unsigned DEAD_CLK   = 8,
  parameter int unsigned MIN_RELOAD = 16,
  parameter int unsigned RCNT_W     = 16
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [24:0]       m3r_step_cnt_reload1,
  input  logic              m3s_run,
  input  logic              m3s_dir,
  output logic [2:0]        m3s_step_idx,
  output logic              m3s_step_pulse,
  output logic              m3s_round_pulse,
  output logic [RCNT_W-1:0] m3s_round_cnt,
  output logic [2:0]        m3s_phase_hi,
  output logic [2:0]        m3s_phase_lo,
  output logic              m3s_running
);

  localparam int unsigned    DCW       = (DEAD_CLK > 2) ? $clog2(DEAD_CLK) : 1;
  localparam logic [DCW-1:0] DEAD_LOAD = DCW'((DEAD_CLK > 0) ? (DEAD_CLK - 1) : 0);
  localparam logic [24:0]    MIN_RL    = 25'(MIN_RELOAD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DRIVE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [24:0]         cnt_q, cnt_d;
  logic [DCW-1:0]      dead_q, dead_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic                sp_q, sp_d;
  logic                rp_q, rp_d;
  logic [2:0]          hi_q, hi_d;
  logic [2:0]          lo_q, lo_d;
  logic                run_q, run_d;
  logic [24:0]         reload_eff;
  logic                start;
  logic                wrap;

  // Commutation table, returns {hi, lo} as {W,V,U} each.
  function automatic logic [5:0] phase_tab(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_tab = {3'b001, 3'b010};
      3'd1:    phase_tab = {3'b001, 3'b100};
      3'd2:    phase_tab = {3'b010, 3'b100};
      3'd3:    phase_tab = {3'b010, 3'b001};
      3'd4:    phase_tab = {3'b100, 3'b001};
      3'd5:    phase_tab = {3'b100, 3'b010};
      default: phase_tab = '0;
    endcase
  endfunction

  assign reload_eff = (m3r_step_cnt_reload1 < MIN_RL) ? MIN_RL : m3r_step_cnt_reload1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dead_d  = dead_q;
    rcnt_d  = rcnt_q;
    sp_d    = 1'b0;
    rp_d    = 1'b0;
    hi_d    = '0;
    lo_d    = '0;
    start   = 1'b0;
    wrap    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m3s_run) start = 1'b1;
      end
      ST_DEAD, ST_DRIVE: begin
        if (!m3s_run) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          start = 1'b1;
          if (m3s_dir) begin
            if (idx_q == 3'd0 || idx_q > 3'd5) begin
              idx_d = 3'd5;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q - 3'd1;
            end
          end else if (idx_q >= 3'd5) begin
            idx_d = 3'd0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 25'd1;
          if (state_q == ST_DEAD && dead_q != '0) begin
            dead_d = dead_q - DCW'(1);
          end else begin
            // Phases are registered, so they are computed one cycle ahead:
            // the last dead cycle already loads the DRIVE pattern.
            state_d = ST_DRIVE;
            if (idx_q > 3'd5) idx_d = 3'd0;
            else {hi_d, lo_d} = phase_tab(idx_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      cnt_d   = reload_eff - 25'd1;
      dead_d  = DEAD_LOAD;
      sp_d    = 1'b1;
      state_d = (DEAD_CLK == 0) ? ST_DRIVE : ST_DEAD;
    end

    if (wrap) begin
      rp_d   = 1'b1;
      rcnt_d = rcnt_q + RCNT_W'(1);
    end

    run_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= '0;
      rcnt_q  <= '0;
      sp_q    <= 1'b0;
      rp_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dead_q  <= dead_d;
      rcnt_q  <= rcnt_d;
      sp_q    <= sp_d;
      rp_q    <= rp_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      run_q   <= run_d;
    end
  end

  assign m3s_step_idx    = idx_q;
  assign m3s_step_pulse  = sp_q;
  assign m3s_round_pulse = rp_q;
  assign m3s_round_cnt   = rcnt_q;
  assign m3s_phase_hi    = hi_q;
  assign m3s_phase_lo    = lo_q;
  assign m3s_running     = run_q;

endmodule

// File: tb/tb_motoro3_step_seq.sv
// Testbench for motoro3_step_seq: table-driven checkpoints plus directed
// sequences for clamping, speed/direction change, abort/resume and reset.
module tb_motoro3_step_seq;

  logic        clk = 1'b0;
  logic        nRst;
  logic [24:0] reload;
  logic        run;
  logic        dir;
  logic [2:0]  idx;
  logic        sp;
  logic        rp;
  logic [15:0] rcnt;
  logic [2:0]  hi;
  logic [2:0]  lo;
  logic        running;

  int checks = 0;
  int errors = 0;

  motoro3_step_seq #(
    .DEAD_CLK  (8),
    .MIN_RELOAD(16),
    .RCNT_W    (16)
  ) dut (
    .clk                 (clk),
    .nRst                (nRst),
    .m3r_step_cnt_reload1(reload),
    .m3s_run             (run),
    .m3s_dir             (dir),
    .m3s_step_idx        (idx),
    .m3s_step_pulse      (sp),
    .m3s_round_pulse     (rp),
    .m3s_round_cnt       (rcnt),
    .m3s_phase_hi        (hi),
    .m3s_phase_lo        (lo),
    .m3s_running         (running)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic        run;
    logic        dir;
    logic [24:0] reload;
    int          adv;
    logic [2:0]  idx;
    logic        sp;
    logic        rp;
    logic [15:0] rcnt;
    logic [2:0]  hi;
    logic [2:0]  lo;
    logic        running;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_idx, input logic e_sp,
                         input logic e_rp, input logic [15:0] e_rcnt, input logic [2:0] e_hi,
                         input logic [2:0] e_lo, input logic e_run);
    chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
    chk({tag, ".step_pulse"}, 32'(sp), 32'(e_sp));
    chk({tag, ".round_pulse"}, 32'(rp), 32'(e_rp));
    chk({tag, ".round_cnt"}, 32'(rcnt), 32'(e_rcnt));
    chk({tag, ".hi"}, 32'(hi), 32'(e_hi));
    chk({tag, ".lo"}, 32'(lo), 32'(e_lo));
    chk({tag, ".running"}, 32'(running), 32'(e_run));
  endtask

  // Cycles from the current negedge until the next observed step_pulse.
  task automatic wait_pulse(input string name, input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sp && n < maxc);
    if (!sp) chk({name, ".timeout"}, 32'(sp), 32'd1);
  endtask

  function automatic void add(input logic r, input logic d, input logic [24:0] rl, input int a,
                              input logic [2:0] i, input logic s, input logic p,
                              input logic [15:0] c, input logic [2:0] h, input logic [2:0] l,
                              input logic rn);
    vecs.push_back('{r, d, rl, a, i, s, p, c, h, l, rn});
  endfunction

  // Phase-safety invariants checked every cycle.
  always @(negedge clk) begin
    chk("no_shoot_through", 32'(hi & lo), 32'd0);
    if (sp) chk("no_drive_on_step_pulse", 32'(hi | lo), 32'd0);
  end

  initial begin
    int n;
    int n2;

    // Forward run, edges counted from run=1 (edge 1 = first step start).
    add(1, 0, 40,  1, 0, 1, 0, 0, 3'b000, 3'b000, 1); // e1 step start
    add(1, 0, 40,  7, 0, 0, 0, 0, 3'b000, 3'b000, 1); // e8 last dead cycle
    add(1, 0, 40,  1, 0, 0, 0, 0, 3'b001, 3'b010, 1); // e9 first drive
    add(1, 0, 40, 31, 0, 0, 0, 0, 3'b001, 3'b010, 1); // e40 last drive
    add(1, 0, 40,  1, 1, 1, 0, 0, 3'b000, 3'b000, 1); // e41 idx1
    add(1, 0, 40,  8, 1, 0, 0, 0, 3'b001, 3'b100, 1); // e49
    add(1, 0, 40, 32, 2, 1, 0, 0, 3'b000, 3'b000, 1); // e81
    add(1, 0, 40, 40, 3, 1, 0, 0, 3'b000, 3'b000, 1); // e121
    add(1, 0, 40, 40, 4, 1, 0, 0, 3'b000, 3'b000, 1); // e161
    add(1, 0, 40, 40, 5, 1, 0, 0, 3'b000, 3'b000, 1); // e201
    add(1, 0, 40, 40, 0, 1, 1, 1, 3'b000, 3'b000, 1); // e241 wrap
    add(1, 0, 40,  1, 0, 0, 0, 1, 3'b000, 3'b000, 1); // e242
    // Reverse from idx 0.
    add(1, 1, 40, 39, 5, 1, 1, 2, 3'b000, 3'b000, 1); // e281 wrap 0->5
    add(1, 1, 40, 40, 4, 1, 0, 2, 3'b000, 3'b000, 1);
    add(1, 1, 40, 120, 1, 1, 0, 2, 3'b000, 3'b000, 1);
    add(1, 1, 40, 40, 0, 1, 0, 2, 3'b000, 3'b000, 1);
    add(1, 1, 40, 40, 5, 1, 1, 3, 3'b000, 3'b000, 1);
    add(1, 1, 40, 10, 5, 0, 0, 3, 3'b100, 3'b010, 1); // mid-drive idx5

    // Reset held with run=1.
    nRst = 1'b0; run = 1'b1; dir = 1'b0; reload = 25'd40;
    step(3);
    chk_all("reset", 0, 0, 0, 0, 3'b000, 3'b000, 0);
    nRst = 1'b1; run = 1'b0;
    step(3);
    chk_all("idle", 0, 0, 0, 0, 3'b000, 3'b000, 0);

    foreach (vecs[k]) begin
      run = vecs[k].run; dir = vecs[k].dir; reload = vecs[k].reload;
      step(vecs[k].adv);
      chk_all($sformatf("vec%0d", k), vecs[k].idx, vecs[k].sp, vecs[k].rp, vecs[k].rcnt,
              vecs[k].hi, vecs[k].lo, vecs[k].running);
    end

    // Reset mid-DRIVE overrides everything.
    nRst = 1'b0;
    step(1);
    chk_all("reset_mid_drive", 0, 0, 0, 0, 3'b000, 3'b000, 0);
    nRst = 1'b1; run = 1'b0; dir = 1'b0;
    step(1);

    // Clamp: reload below MIN_RELOAD.
    reload = 25'd3; run = 1'b1;
    wait_pulse("clamp_first", 10, n);
    wait_pulse("clamp3", 100, n);
    chk("clamp3_period", 32'(n), 32'd16);
    reload = 25'd0;
    wait_pulse("clamp0a", 100, n);
    wait_pulse("clamp0b", 100, n);
    chk("clamp0_period", 32'(n), 32'd16);
    chk("clamp0_idx", 32'(idx), 32'd3);

    // Speed and direction change mid-step apply at the boundary.
    run = 1'b0; nRst = 1'b0;
    step(1);
    nRst = 1'b1; reload = 25'd40; run = 1'b1; dir = 1'b0;
    wait_pulse("speed_first", 10, n);
    step(5);
    reload = 25'd80; dir = 1'b1;
    step(15);
    chk("speed_idx_held", 32'(idx), 32'd0);
    wait_pulse("speed_a", 200, n);
    chk("speed_old_period", 32'(n + 20), 32'd40);
    chk("dir_idx", 32'(idx), 32'd5);
    chk("dir_round", 32'(rp), 32'd1);
    wait_pulse("speed_b", 200, n2);
    chk("speed_new_period", 32'(n2), 32'd80);
    chk("dir_idx2", 32'(idx), 32'd4);

    // Abort in idx-2 step and resume.
    run = 1'b0; nRst = 1'b0;
    step(1);
    nRst = 1'b1; reload = 25'd40; dir = 1'b0; run = 1'b1;
    wait_pulse("abort_s0", 10, n);
    wait_pulse("abort_s1", 100, n);
    wait_pulse("abort_s2", 100, n);
    chk("abort_at_idx2", 32'(idx), 32'd2);
    step(20);
    run = 1'b0;
    step(1);
    chk_all("abort", 2, 0, 0, 0, 3'b000, 3'b000, 0);
    step(5);
    chk_all("abort_hold", 2, 0, 0, 0, 3'b000, 3'b000, 0);
    run = 1'b1;
    step(1);
    chk_all("resume", 2, 1, 0, 0, 3'b000, 3'b000, 1);
    step(7);
    chk_all("resume_dead", 2, 0, 0, 0, 3'b000, 3'b000, 1);
    step(1);
    chk_all("resume_drive", 2, 0, 0, 0, 3'b010, 3'b100, 1);
    wait_pulse("resume_full", 100, n);
    chk("resume_period", 32'(n + 8), 32'd40);
    chk("resume_next_idx", 32'(idx), 32'd3);

    // run=0 coinciding with counter expiry: run=0 wins.
    step(39);
    run = 1'b0;
    step(1);
    chk_all("stop_at_end", 3, 0, 0, 0, 3'b000, 3'b000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motoro3_step_seq.md
Name: motoro3_step_seq

Overview:
6-step (trapezoidal) commutation sequencer for the 3-phase motor, directly downstream of the motoro3 register block. It consumes m3r_step_cnt_reload1 as the step period in clk cycles. It walks the electrical step index 0..5 and drives registered high-side/low-side phase enables, inserting dead time at every step change. It also issues step and electrical-revolution pulses for the PWM/gate stage and for monitoring.

Parameters:
DEAD_CLK, 8, clk cycles with all phase enables off at the start of every step (0 = no dead time)
MIN_RELOAD, 16, floor applied to the step period; must be > DEAD_CLK
RCNT_W, 16, width of the electrical-revolution counter

Ports:
clk  in  1  system clock, 10 MHz
nRst  in  1  reset, synchronous, active-low
m3r_step_cnt_reload1  in  25  step period in clk cycles
m3s_run  in  1  1 = sequence runs, 0 = stop and drive nothing
m3s_dir  in  1  0 = forward (idx+1), 1 = reverse (idx-1)
m3s_step_idx  out  3  current electrical step, 0..5
m3s_step_pulse  out  1  one-cycle pulse when a step begins
m3s_round_pulse  out  1  one-cycle pulse on idx wrap (5->0 forward, 0->5 reverse)
m3s_round_cnt  out  RCNT_W  count of round_pulse, wraps
m3s_phase_hi  out  3  high-side enables {W,V,U}
m3s_phase_lo  out  3  low-side enables {W,V,U}
m3s_running  out  1  1 when state is DEAD or DRIVE

Behaviour:
- All outputs registered. Reset when nRst=0 at a clk edge: state IDLE, idx 0, all pulses 0, phase_hi/lo 0, round_cnt 0, running 0, counters 0. Reset overrides everything, including mid-step.
- reload_eff = max(m3r_step_cnt_reload1, MIN_RELOAD). Sampled only at step start, so speed changes take effect at the next step boundary.
- m3s_dir is sampled only at a step boundary.
- States: IDLE, DEAD, DRIVE.
- IDLE: phases 0, running 0, idx held.
  - run=1 at an edge: step starts at the current idx (no advance).
  - Step start means: load step counter with reload_eff-1; step_pulse=1 for one cycle; go to DEAD (or directly to DRIVE if DEAD_CLK=0).
- DEAD: phases 0 for exactly DEAD_CLK cycles counted from the step start edge, then DRIVE.
- DRIVE: phases follow the table for the current idx, as {W,V,U} hi / lo:
  - idx 0: hi 001 / lo 010
  - idx 1: hi 001 / lo 100
  - idx 2: hi 010 / lo 100
  - idx 3: hi 010 / lo 001
  - idx 4: hi 100 / lo 001
  - idx 5: hi 100 / lo 010
  - idx 6 or 7 (unreachable): phases 0, idx forced to 0.
- Step counter decrements by 1 every cycle in DEAD and DRIVE. Total step length is reload_eff cycles: DEAD_CLK off cycles plus reload_eff-DEAD_CLK driven cycles.
- Counter reaching 0 with run=1 at the edge:
  - idx advances mod 6 per sampled dir.
  - New step start: step_pulse=1, DEAD, phases 0.
  - On wrap: round_pulse=1 in the same cycle as step_pulse, and round_cnt+1 (wraps at 2^RCNT_W-1 -> 0).
- run=0 at any edge in DEAD/DRIVE:
  - Next cycle: IDLE, phases 0, idx held, no pulses. The partial step is abandoned.
  - A later run=1 restarts the same idx with a full step.
- run=0 together with counter reaching 0: run=0 wins. No advance, no pulses.
- phase_hi and phase_lo are never both 1 on the same phase.
- phase_hi/lo are never nonzero in the cycle of step_pulse.

Test Plan:
1. Reset: nRst=0 for 3 cycles with run=1 -> all outputs 0, idx 0; nRst=1, run=0 -> stays IDLE, phases 0.
2. Forward run: DEAD_CLK=8, reload=40, dir=0, run=1.
   - step_pulse every 40 cycles; first step phases 0 for 8 cycles, then hi=001 lo=010 for 32 cycles.
   - idx sequence 0,1,2,3,4,5,0; round_pulse coincides with the 5->0 step_pulse; round_cnt=1 after 240 cycles.
3. Reverse: from idx 0 with dir=1 -> next idx 5 with round_pulse; sequence 5,4,3,2,1,0,5.
4. Clamp: reload=3, MIN_RELOAD=16 -> step_pulse period 16 cycles. Reload=0 -> period 16.
5. Speed change: reload 40 -> 80 written mid-step -> current step still 40 cycles, next step 80; dir toggled mid-step applies only at the boundary.
6. Abort/resume:
   - run dropped at cycle 20 of an idx-2 step -> next cycle phases 0, running 0, idx 2.
   - run=1 again -> step_pulse, 8 dead cycles, hi=010 lo=100.
   - nRst=0 mid-DRIVE -> reset values on the next edge.
